condicionador_botoes: RTL

CONDICIONADOR_BOTOES -- requirements
Module: condicionador_botoes

---
 rtl/condicionador_botoes.sv | 81 ++++++++
 1 files changed

// File: rtl/condicionador_botoes.sv
// condicionador_botoes: button debouncer that turns one press into one play pulse
// Optional CONDICIONADOR_BOTOES_INVALIDA_EN flags qualified presses that are not one-hot.
module condicionador_botoes #(
  parameter int CICLOS_DEBOUNCE = 20
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       habilita,
  input  logic       limpa,
  input  logic [3:0] botoes,
  output logic [3:0] jogada,
  output logic       tem_jogada,
  output logic       jogada_invalida,
  output logic [2:0] db_estado
);
  localparam int CW = $clog2(CICLOS_DEBOUNCE);
  localparam logic [CW-1:0] FIM = CW'(CICLOS_DEBOUNCE - 1);
  typedef enum logic [2:0] {
    OCIOSO          = 3'd0,
    ESTABILIZA      = 3'd1,
    DISPARA         = 3'd2,
    AGUARDA_SOLTURA = 3'd3,
    SOLTURA         = 3'd4
  } estado_t;
  estado_t estado, prox;
  logic [3:0] s1, s, cand, cand_n;
  logic [CW-1:0] cnt, cnt_n;
  logic um_quente;
  assign um_quente = (cand != '0) && ((cand & (cand - 4'd1)) == '0);
  assign tem_jogada = (estado == DISPARA) && um_quente;
`ifdef CONDICIONADOR_BOTOES_INVALIDA_EN
  assign jogada_invalida = (estado == DISPARA) && !um_quente;
`else
  assign jogada_invalida = 1'b0;
`endif
  assign db_estado = estado;
  always_ff @(posedge clock or negedge reset)
    if (!reset) begin
      s1     <= '0;
      s      <= '0;
      estado <= OCIOSO;
      cnt    <= '0;
      cand   <= '0;
      jogada <= '0;
    end else begin
      s1     <= botoes;
      s      <= s1;
      estado <= prox;
      cnt    <= cnt_n;
      cand   <= cand_n;
      jogada <= limpa ? '0 : (tem_jogada ? cand : jogada);
    end
  always_comb begin
    prox   = estado;
    cnt_n  = cnt;
    cand_n = cand;
    case (estado)
      OCIOSO:
        if (habilita && s != '0) begin
          cand_n = s;
          cnt_n  = '0;
          prox   = ESTABILIZA;
        end
      ESTABILIZA:
        if (s != cand || !habilita) prox = OCIOSO;
        else if (cnt == FIM) prox = DISPARA;
        else cnt_n = cnt + 1'b1;
      DISPARA: prox = AGUARDA_SOLTURA;
      AGUARDA_SOLTURA:
        if (s == '0) begin
          cnt_n = '0;
          prox  = SOLTURA;
        end
      SOLTURA:
        if (s != '0) prox = AGUARDA_SOLTURA;
        else if (cnt == FIM) prox = OCIOSO;
        else cnt_n = cnt + 1'b1;
      default: prox = OCIOSO;
    endcase
  end
endmodule
